// File: rtl/dti_decouple.sv
// dti_decouple: registered DTI decoupling FIFO.
// A DTI consumer on din feeds a DEPTH-entry register array, and a DTI producer
// on dout drains it. Both handshake outputs come from registered pointers, so
// no combinational path runs from din_* to dout_* or from dout_ready to din_ready.
// With DEPTH >= 2 it sustains one transfer per cycle. There is no fall-through,
// so a word pushed at edge N appears on dout in the cycle after edge N.
module dti_decouple #(
    parameter int W_DATA = 16,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [W_DATA-1:0] din_data,
    input  logic              din_valid,
    output logic              din_ready,
    output logic [W_DATA-1:0] dout_data,
    output logic              dout_valid,
    input  logic              dout_ready
);

    // Pointer index width. The extra MSB on each pointer is the wrap bit that
    // tells full apart from empty when the index bits match.
    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0][W_DATA-1:0] mem;
    logic [AW:0]                  wr_ptr;
    logic [AW:0]                  rd_ptr;
    logic                         full;
    logic                         empty;
    logic                         push;
    logic                         pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

    // The handshake outputs depend only on registered pointers and on rst.
    // Gating with rst holds both sides idle while reset is low, so a push or pop
    // offered during a reset cycle is never taken.
    assign din_ready  = rst && !full;
    assign dout_valid = rst && !empty;
    assign dout_data  = mem[rd_ptr[AW-1:0]];

    assign push = din_valid && din_ready;
    assign pop  = dout_valid && dout_ready;

    // The pointers advance on each handshake. They are AW+1 bits wide, so they
    // wrap naturally modulo 2*DEPTH. Reset clears both pointers and drops any
    // buffered words.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage write. The array is not reset, because the empty pointers already
    // hide any stale contents.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= din_data;
    end

endmodule

// File: tb/tb_dti_decouple.sv
// Directed bench for dti_decouple. u_d2 (DEPTH=2) covers streaming.
// u_d4 (DEPTH=4) covers backpressure, wrap-around, isolation and mid-operation reset.
module tb_dti_decouple;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    logic        rst2, d2_din_valid, d2_din_ready, d2_dout_valid, d2_dout_ready;
    logic [15:0] d2_din_data, d2_dout_data;
    logic        rst4, d4_din_valid, d4_din_ready, d4_dout_valid, d4_dout_ready;
    logic [15:0] d4_din_data, d4_dout_data;

    dti_decouple #(.W_DATA(16), .DEPTH(2)) u_d2 (
        .clk(clk), .rst(rst2),
        .din_data(d2_din_data), .din_valid(d2_din_valid), .din_ready(d2_din_ready),
        .dout_data(d2_dout_data), .dout_valid(d2_dout_valid), .dout_ready(d2_dout_ready)
    );

    dti_decouple #(.W_DATA(16), .DEPTH(4)) u_d4 (
        .clk(clk), .rst(rst4),
        .din_data(d4_din_data), .din_valid(d4_din_valid), .din_ready(d4_din_ready),
        .dout_data(d4_dout_data), .dout_valid(d4_dout_valid), .dout_ready(d4_dout_ready)
    );

    // Upstream rule: a word offered but not accepted stays offered, unchanged.
    a_hold2: assert property (@(posedge clk) disable iff (!rst2)
        (rst2 && d2_din_valid && !d2_din_ready) |=> (d2_din_valid && $stable(d2_din_data)));
    a_hold4: assert property (@(posedge clk) disable iff (!rst4)
        (rst4 && d4_din_valid && !d4_din_ready) |=> (d4_din_valid && $stable(d4_din_data)));

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst2 = 1'b0; rst4 = 1'b0;
        d2_din_valid = 1'b1; d4_din_valid = 1'b1;
        d2_din_data = 16'hDEAD; d4_din_data = 16'hBEEF;
        d2_dout_ready = 1'b1; d4_dout_ready = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (d2_din_ready !== 1'b0) $display("FAIL reset_d2_din_ready cyc%0d got %b exp 0", i, d2_din_ready); else passed++;
            checks++; if (d2_dout_valid !== 1'b0) $display("FAIL reset_d2_dout_valid cyc%0d got %b exp 0", i, d2_dout_valid); else passed++;
            checks++; if (d4_din_ready !== 1'b0) $display("FAIL reset_d4_din_ready cyc%0d got %b exp 0", i, d4_din_ready); else passed++;
            checks++; if (d4_dout_valid !== 1'b0) $display("FAIL reset_d4_dout_valid cyc%0d got %b exp 0", i, d4_dout_valid); else passed++;
        end
        rst2 = 1'b1; rst4 = 1'b1;
        d2_din_valid = 1'b0; d4_din_valid = 1'b0;
        #1;
        checks++; if (d2_din_ready !== 1'b1) $display("FAIL release_d2_din_ready got %b exp 1", d2_din_ready); else passed++;
        checks++; if (d4_din_ready !== 1'b1) $display("FAIL release_d4_din_ready got %b exp 1", d4_din_ready); else passed++;
        checks++; if (d2_dout_valid !== 1'b0) $display("FAIL release_d2_dout_valid got %b exp 0", d2_dout_valid); else passed++;
        checks++; if (d4_dout_valid !== 1'b0) $display("FAIL release_d4_dout_valid got %b exp 0", d4_dout_valid); else passed++;
        step(); step();
        checks++; if (d2_dout_valid !== 1'b0) $display("FAIL idle_d2_dout_valid got %b exp 0", d2_dout_valid); else passed++;
        checks++; if (d4_dout_valid !== 1'b0) $display("FAIL idle_d4_dout_valid got %b exp 0", d4_dout_valid); else passed++;
    endtask

    // 64 words, back-to-back, DEPTH=2. Word k is pushed at edge k and shown after it.
    task automatic test_streaming;
        d2_dout_ready = 1'b1;
        d2_din_valid  = 1'b1;
        d2_din_data   = 16'h0001;
        for (int k = 1; k <= 64; k++) begin
            step();
            checks++; if (d2_dout_valid !== 1'b1) $display("FAIL stream_valid word%0d got %b exp 1", k, d2_dout_valid); else passed++;
            checks++; if (d2_dout_data !== 16'(k)) $display("FAIL stream_data word%0d got %h exp %h", k, d2_dout_data, 16'(k)); else passed++;
            checks++; if (d2_din_ready !== 1'b1) $display("FAIL stream_din_ready word%0d got %b exp 1", k, d2_din_ready); else passed++;
            if (k < 64) d2_din_data = 16'(k + 1);
            else        d2_din_valid = 1'b0;
        end
        step();
        checks++; if (d2_dout_valid !== 1'b0) $display("FAIL stream_end_valid got %b exp 0", d2_dout_valid); else passed++;
    endtask

    task automatic test_fill_backpressure;
        d4_dout_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            d4_din_valid = 1'b1;
            d4_din_data  = 16'hA0 + 16'(i);
            step();
            checks++; if (d4_din_ready !== (i < 3)) $display("FAIL fill_din_ready push%0d got %b exp %b", i, d4_din_ready, (i < 3)); else passed++;
            checks++; if (d4_dout_data !== 16'hA0) $display("FAIL fill_head push%0d got %h exp a0", i, d4_dout_data); else passed++;
        end
        d4_din_data = 16'hA4;
        step(); step();
        checks++; if (d4_din_ready !== 1'b0) $display("FAIL full_hold_din_ready got %b exp 0", d4_din_ready); else passed++;
        checks++; if (d4_dout_valid !== 1'b1 || d4_dout_data !== 16'hA0) $display("FAIL full_hold_head got %b/%h exp 1/a0", d4_dout_valid, d4_dout_data); else passed++;
        d4_dout_ready = 1'b1;
        step();
        checks++; if (d4_din_ready !== 1'b1) $display("FAIL after_pop_din_ready got %b exp 1", d4_din_ready); else passed++;
        checks++; if (d4_dout_data !== 16'hA1) $display("FAIL drain_a1 got %h exp a1", d4_dout_data); else passed++;
        step();
        checks++; if (d4_dout_data !== 16'hA2) $display("FAIL drain_a2 got %h exp a2", d4_dout_data); else passed++;
        checks++; if (d4_din_ready !== 1'b1) $display("FAIL drain_din_ready got %b exp 1", d4_din_ready); else passed++;
        d4_din_data = 16'hA5;
        step();
        checks++; if (d4_dout_data !== 16'hA3) $display("FAIL drain_a3 got %h exp a3", d4_dout_data); else passed++;
        d4_din_valid = 1'b0;
        step();
        checks++; if (d4_dout_data !== 16'hA4) $display("FAIL drain_a4 got %h exp a4", d4_dout_data); else passed++;
        step();
        checks++; if (d4_dout_valid !== 1'b1 || d4_dout_data !== 16'hA5) $display("FAIL drain_a5 got %b/%h exp 1/a5", d4_dout_valid, d4_dout_data); else passed++;
        step();
        checks++; if (d4_dout_valid !== 1'b0) $display("FAIL drain_empty got %b exp 0", d4_dout_valid); else passed++;
    endtask

    // Wiggle din_valid and dout_ready mid-cycle. The other side must not move.
    task automatic test_isolation;
        d4_dout_ready = 1'b1;
        d4_din_valid  = 1'b1;
        #1;
        checks++; if (d4_dout_valid !== 1'b0) $display("FAIL iso_din_valid_to_dout_valid got %b exp 0", d4_dout_valid); else passed++;
        d4_din_valid  = 1'b0;
        d4_dout_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            d4_din_valid = 1'b1;
            d4_din_data  = 16'h10 + 16'(i);
            step();
        end
        d4_din_valid = 1'b0;
        d4_dout_ready = 1'b1;
        #1;
        checks++; if (d4_din_ready !== 1'b0) $display("FAIL iso_dout_ready_hi_to_din_ready got %b exp 0", d4_din_ready); else passed++;
        d4_dout_ready = 1'b0;
        #1;
        checks++; if (d4_din_ready !== 1'b0) $display("FAIL iso_dout_ready_lo_to_din_ready got %b exp 0", d4_din_ready); else passed++;
        d4_dout_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (d4_dout_data !== 16'h10 + 16'(i)) $display("FAIL iso_drain%0d got %h exp %h", i, d4_dout_data, 16'h10 + 16'(i)); else passed++;
            step();
        end
        checks++; if (d4_dout_valid !== 1'b0) $display("FAIL iso_empty got %b exp 0", d4_dout_valid); else passed++;
    endtask

    task automatic test_random_wrap;
        logic [15:0] q[$];
        logic        pend = 1'b0;
        logic        do_push, do_pop;
        int          errs = 0;
        for (int c = 0; c < 10000; c++) begin
            checks++; if (d4_din_ready !== (q.size() < 4)) begin
                if (errs++ < 10) $display("FAIL rnd_din_ready cyc%0d got %b exp %b", c, d4_din_ready, (q.size() < 4));
            end else passed++;
            checks++; if (d4_dout_valid !== (q.size() > 0)) begin
                if (errs++ < 10) $display("FAIL rnd_dout_valid cyc%0d got %b exp %b", c, d4_dout_valid, (q.size() > 0));
            end else passed++;
            if (q.size() > 0) begin
                checks++; if (d4_dout_data !== q[0]) begin
                    if (errs++ < 10) $display("FAIL rnd_data cyc%0d got %h exp %h", c, d4_dout_data, q[0]);
                end else passed++;
            end
            if (!pend) begin
                d4_din_valid = 1'($urandom_range(0, 1));
                d4_din_data  = 16'($urandom);
            end
            d4_dout_ready = 1'($urandom_range(0, 1));
            do_push = d4_din_valid && (q.size() < 4);
            do_pop  = d4_dout_ready && (q.size() > 0);
            pend    = d4_din_valid && !do_push;
            if (do_pop)  void'(q.pop_front());
            if (do_push) q.push_back(d4_din_data);
            step();
        end
        d4_din_valid  = 1'b0;
        d4_dout_ready = 1'b1;
        for (int i = 0; i < 8 && q.size() > 0; i++) begin
            checks++; if (d4_dout_data !== q[0]) $display("FAIL rnd_drain got %h exp %h", d4_dout_data, q[0]); else passed++;
            void'(q.pop_front());
            step();
        end
        checks++; if (d4_dout_valid !== 1'b0) $display("FAIL rnd_final_empty got %b exp 0", d4_dout_valid); else passed++;
    endtask

    task automatic test_mid_reset;
        d4_dout_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            d4_din_valid = 1'b1;
            d4_din_data  = 16'h11 * 16'(i + 1);
            step();
        end
        d4_din_valid = 1'b0;
        rst4 = 1'b0;
        #1;
        checks++; if (d4_din_ready !== 1'b0 || d4_dout_valid !== 1'b0) $display("FAIL midrst_low got rdy %b vld %b exp 0/0", d4_din_ready, d4_dout_valid); else passed++;
        step();
        rst4 = 1'b1;
        #1;
        checks++; if (d4_dout_valid !== 1'b0) $display("FAIL midrst_flushed got %b exp 0", d4_dout_valid); else passed++;
        checks++; if (d4_din_ready !== 1'b1) $display("FAIL midrst_din_ready got %b exp 1", d4_din_ready); else passed++;
        d4_din_valid  = 1'b1;
        d4_din_data   = 16'h0055;
        d4_dout_ready = 1'b1;
        step();
        d4_din_valid = 1'b0;
        checks++; if (d4_dout_valid !== 1'b1 || d4_dout_data !== 16'h0055) $display("FAIL midrst_word got %b/%h exp 1/0055", d4_dout_valid, d4_dout_data); else passed++;
        step();
        checks++; if (d4_dout_valid !== 1'b0) $display("FAIL midrst_after got %b exp 0", d4_dout_valid); else passed++;
        step();
        checks++; if (d4_dout_valid !== 1'b0) $display("FAIL midrst_after2 got %b exp 0", d4_dout_valid); else passed++;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_streaming();
        test_fill_backpressure();
        test_isolation();
        test_random_wrap();
        test_mid_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
